// File: rtl/element_pulse_sched.sv
// Purpose : timed command scheduler in front of one ifelement; queues up to DEPTH
//           pulse commands and launches each when tcnt reaches its trigger time.
// Latency : cmdstb rises on the edge after tcnt==trigt is seen in ARM with the element idle.
// Backpr. : cmd_ready = queue not full (or flush); elem_busy holds a due command in ARM.
// Ports   : clk/reset_n     clock, async active-low reset
//           flush           sync drop of queue and drive registers (late_cnt kept)
//           cmd_*           command input (valid/ready), trigt = trigger time
//           tcnt            shared wrapping time counter; elem_busy = element busy
//           envstart..pini  registered drive to the element; cmdstb = launch strobe
//           late/late_cnt   late-issue pulse and saturating count; qcount = queue fill
module element_pulse_sched #(
  parameter int DEPTH          = 4,
  parameter int TCNTWIDTH      = 27,
  parameter int ENV_ADDRWIDTH  = 32,
  parameter int FREQ_ADDRWIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [TCNTWIDTH-1:0]        cmd_trigt,
  input  logic [ENV_ADDRWIDTH-1:0]    cmd_envstart,
  input  logic [ENV_ADDRWIDTH-1:0]    cmd_envlength,
  input  logic [15:0]                 cmd_ampx,
  input  logic [FREQ_ADDRWIDTH-1:0]   cmd_freqaddr,
  input  logic [16:0]                 cmd_pini,
  input  logic [TCNTWIDTH-1:0]        tcnt,
  input  logic                        elem_busy,
  output logic [ENV_ADDRWIDTH-1:0]    envstart,
  output logic [ENV_ADDRWIDTH-1:0]    envlength,
  output logic [15:0]                 ampx,
  output logic [FREQ_ADDRWIDTH-1:0]   freqaddr,
  output logic [16:0]                 pini,
  output logic                        cmdstb,
  output logic                        late,
  output logic [15:0]                 late_cnt,
  output logic [$clog2(DEPTH):0]      qcount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [TCNTWIDTH-1:0]      trigt;
    logic [ENV_ADDRWIDTH-1:0]  envstart;
    logic [ENV_ADDRWIDTH-1:0]  envlength;
    logic [15:0]               ampx;
    logic [FREQ_ADDRWIDTH-1:0] freqaddr;
    logic [16:0]               pini;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ARM, FIRE, HOLD} state_t;

  cmd_t              mem [DEPTH];
  cmd_t              cmd_in;
  cmd_t              head;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  state_t            state;
  logic [1:0]        hold_cnt;
  logic [TCNTWIDTH-1:0] d;
  logic              due;
  logic              not_full;
  logic              enq;
  logic              deq;

  assign cmd_in = '{trigt: cmd_trigt, envstart: cmd_envstart, envlength: cmd_envlength,
                    ampx: cmd_ampx, freqaddr: cmd_freqaddr, pini: cmd_pini};

  assign not_full  = (qcount < DEPTH_C);
  // During flush the offered command is swallowed, so it is always accepted.
  assign cmd_ready = flush | not_full;
  assign enq       = cmd_valid & not_full & ~flush;

  assign head = mem[rd_ptr];
  // Modular distance from trigger to now; MSB clear means now is at/after trigger
  // within a half-range window, MSB set means the trigger is still ahead.
  assign d   = tcnt - head.trigt;
  assign due = ~d[TCNTWIDTH-1];
  assign deq = (state == ARM) & due & ~elem_busy & ~flush;

  // Queue storage needs no reset; validity is tracked by qcount.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      qcount    <= '0;
      state     <= IDLE;
      hold_cnt  <= '0;
      envstart  <= '0;
      envlength <= '0;
      ampx      <= '0;
      freqaddr  <= '0;
      pini      <= '0;
      cmdstb    <= 1'b0;
      late      <= 1'b0;
      late_cnt  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      qcount    <= '0;
      state     <= IDLE;
      hold_cnt  <= '0;
      envstart  <= '0;
      envlength <= '0;
      ampx      <= '0;
      freqaddr  <= '0;
      pini      <= '0;
      cmdstb    <= 1'b0;
      late      <= 1'b0;
    end else begin
      cmdstb <= 1'b0;
      late   <= 1'b0;

      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   qcount <= qcount + 1'b1;
        2'b01:   qcount <= qcount - 1'b1;
        default: qcount <= qcount;
      endcase

      case (state)
        IDLE: begin
          if (qcount != '0) state <= ARM;
        end
        ARM: begin
          if (deq) begin
            envstart  <= head.envstart;
            envlength <= head.envlength;
            ampx      <= head.ampx;
            freqaddr  <= head.freqaddr;
            pini      <= head.pini;
            cmdstb    <= 1'b1;
            late      <= (d != '0);
            if ((d != '0) && (late_cnt != 16'hFFFF)) late_cnt <= late_cnt + 16'd1;
            state     <= FIRE;
          end
        end
        FIRE: begin
          hold_cnt <= '0;
          state    <= HOLD;
        end
        HOLD: begin
          // A CW or zero-length command may never raise busy; give up after 4 cycles.
          if (elem_busy || (hold_cnt == 2'd3)) begin
            state <= (qcount != '0) ? ARM : IDLE;
          end else begin
            hold_cnt <= hold_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_element_pulse_sched.sv
// Purpose : self-checking bench for element_pulse_sched (scoreboard of expected launches).
// Latency : each launch is checked at posedge+1 of the strobe cycle against tcnt.
// Backpr. : bench honours cmd_ready; elem_busy is driven per scenario.
module tb_element_pulse_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [26:0] cmd_trigt;
  logic [31:0] cmd_envstart, cmd_envlength;
  logic [15:0] cmd_ampx;
  logic [31:0] cmd_freqaddr;
  logic [16:0] cmd_pini;
  logic [26:0] tcnt;
  logic        elem_busy;
  logic [31:0] envstart, envlength;
  logic [15:0] ampx;
  logic [31:0] freqaddr;
  logic [16:0] pini;
  logic        cmdstb, late;
  logic [15:0] late_cnt;
  logic [2:0]  qcount;

  element_pulse_sched dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_trigt(cmd_trigt),
    .cmd_envstart(cmd_envstart), .cmd_envlength(cmd_envlength), .cmd_ampx(cmd_ampx),
    .cmd_freqaddr(cmd_freqaddr), .cmd_pini(cmd_pini), .tcnt(tcnt), .elem_busy(elem_busy),
    .envstart(envstart), .envlength(envlength), .ampx(ampx), .freqaddr(freqaddr),
    .pini(pini), .cmdstb(cmdstb), .late(late), .late_cnt(late_cnt), .qcount(qcount)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [26:0] t_exp;
    int          tol;
    logic [31:0] es, el;
    logic [15:0] ax;
    logic [31:0] fa;
    logic [16:0] pi;
    logic        lt;
  } sb_t;

  sb_t sbq[$];
  int  errors = 0;
  int  checks = 0;
  int  strobes = 0;
  int  lc_model = 0;

  // One clock: monitor outputs just after the rising edge, then advance tcnt
  // on the falling edge so the DUT sees a stable value at each rising edge.
  task automatic tick();
    sb_t e;
    logic [26:0] dt;
    @(posedge clk);
    #1;
    if (cmdstb === 1'b1) begin
      strobes++;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmdstb: got strobe at tcnt=%0d, required none", tcnt);
      end else begin
        e = sbq.pop_front();
        if ({envstart, envlength, ampx, freqaddr, pini} !== {e.es, e.el, e.ax, e.fa, e.pi}) begin
          errors++;
          $display("FAIL drive_fields: got %h/%h/%h/%h/%h required %h/%h/%h/%h/%h",
                   envstart, envlength, ampx, freqaddr, pini, e.es, e.el, e.ax, e.fa, e.pi);
        end
        checks++;
        if (late !== e.lt) begin
          errors++;
          $display("FAIL late_flag: got %b required %b", late, e.lt);
        end
        checks++;
        dt = tcnt - e.t_exp;
        if (int'(dt) > e.tol) begin
          errors++;
          $display("FAIL strobe_time: got tcnt=%0d required %0d (+%0d)", tcnt, e.t_exp, e.tol);
        end
        if (e.lt) lc_model++;
        checks++;
        if (late_cnt !== 16'(lc_model)) begin
          errors++;
          $display("FAIL late_cnt_at_strobe: got %0d required %0d", late_cnt, lc_model);
        end
      end
    end else if (late !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL late_without_strobe: got late=%b required 0", late);
    end
    @(negedge clk);
    tcnt = tcnt + 27'd1;
  endtask

  task automatic enq(input logic [26:0] t, input logic [31:0] es, input logic [31:0] el,
                     input logic [15:0] ax, input logic [31:0] fa, input logic [16:0] pi,
                     input logic lt, input logic [26:0] t_exp, input int tol, input int budget);
    sb_t e;
    int  n;
    cmd_trigt = t; cmd_envstart = es; cmd_envlength = el;
    cmd_ampx = ax; cmd_freqaddr = fa; cmd_pini = pi;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL enq_timeout: cmd_ready got %b required 1 within %0d cycles", cmd_ready, budget);
    end else begin
      e = '{t_exp: t_exp, tol: tol, es: es, el: el, ax: ax, fa: fa, pi: pi, lt: lt};
      sbq.push_back(e);
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending launches required 0", sbq.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
    end
    checks++;
    if ({envstart, envlength, ampx, freqaddr, pini, cmdstb, late, late_cnt, qcount} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0",
                         {envstart, envlength, ampx, freqaddr, pini, cmdstb, late, late_cnt, qcount});
    end
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int s0;
    s0 = strobes;
    enq(27'd100, 32'd8, 32'd32, 16'h4000, 32'h0000_1234, 17'h1ABCD, 1'b0, 27'd100, 0, 10);
    wait_drain(150);
    repeat (8) tick();
    checks++;
    if ({envstart, envlength, ampx} !== {32'd8, 32'd32, 16'h4000}) begin
      errors++; $display("FAIL single_hold: got %0d/%0d/%h required 8/32/4000", envstart, envlength, ampx);
    end
    checks++;
    if (strobes - s0 != 1) begin
      errors++; $display("FAIL single_strobe_count: got %0d required 1", strobes - s0);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++)
      enq(27'(200 + 100 * i), 32'(16 * i), 32'(64 + i), 16'(16'h1000 + i), 32'(i), 17'(i + 3),
          1'b0, 27'(200 + 100 * i), 0, 10);
    cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b0 || qcount !== 3'd4) begin
      errors++; $display("FAIL fill_full: got ready=%b qcount=%0d required 0/4", cmd_ready, qcount);
    end
    enq(27'd600, 32'd99, 32'd77, 16'h7FFF, 32'hDEAD_BEEF, 17'h10000, 1'b0, 27'd600, 0, 200);
    wait_drain(600);
    repeat (8) tick();
    checks++;
    if (qcount !== 3'd0) begin
      errors++; $display("FAIL fill_qcount_empty: got %0d required 0", qcount);
    end
  endtask

  task automatic test_late();
    tcnt = 27'd80;
    enq(27'd50, 32'd5, 32'd6, 16'h0123, 32'd7, 17'd8, 1'b1, 27'd80, 3, 10);
    wait_drain(10);
    repeat (6) tick();
    checks++;
    if (late_cnt !== 16'd1) begin
      errors++; $display("FAIL late_cnt_one: got %0d required 1", late_cnt);
    end
  endtask

  task automatic test_busy();
    int n;
    tcnt = 27'd985;
    enq(27'd1000, 32'd11, 32'd12, 16'h2222, 32'd13, 17'd14, 1'b1, 27'd1011, 0, 10);
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      tick();
      elem_busy = (tcnt >= 27'd990) && (tcnt <= 27'd1010);
      n++;
    end
    elem_busy = 1'b0;
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL busy_timeout: got %0d pending required 0", sbq.size());
    end
    repeat (6) tick();
  endtask

  task automatic test_wrap();
    tcnt = 27'h7FF_FFFD;
    enq(27'd2, 32'd21, 32'd0, 16'h3333, 32'd23, 17'd24, 1'b0, 27'd2, 0, 10);
    wait_drain(30);
    repeat (6) tick();
  endtask

  task automatic test_flush_reset();
    logic [26:0] b;
    b = tcnt;
    for (int i = 0; i < 3; i++)
      enq(b + 27'(1000 + i), 32'd1, 32'd2, 16'd3, 32'd4, 17'd5, 1'b0, b, 0, 10);
    checks++;
    if (qcount !== 3'd3) begin
      errors++; $display("FAIL flush_pre_qcount: got %0d required 3", qcount);
    end
    flush = 1'b1;
    cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL flush_cmd_ready: got %b required 1", cmd_ready);
    end
    tick();
    flush = 1'b0;
    cmd_valid = 1'b0;
    sbq.delete();
    checks++;
    if ({qcount, envstart, envlength, ampx, freqaddr, pini} !== '0) begin
      errors++; $display("FAIL flush_clear: got q=%0d drive=%h required 0", qcount,
                         {envstart, envlength, ampx, freqaddr, pini});
    end
    checks++;
    if (late_cnt !== 16'(lc_model)) begin
      errors++; $display("FAIL flush_late_cnt_kept: got %0d required %0d", late_cnt, lc_model);
    end
    repeat (30) tick();
    b = tcnt;
    enq(b + 27'd6, 32'd41, 32'd42, 16'd43, 32'd44, 17'd45, 1'b0, b + 27'd6, 0, 10);
    enq(b + 27'd500, 32'd51, 32'd52, 16'd53, 32'd54, 17'd55, 1'b0, b + 27'd500, 0, 10);
    begin : wait_first
      int n;
      n = 0;
      while (sbq.size() != 1 && n < 40) begin
        tick();
        n++;
      end
    end
    checks++;
    if (sbq.size() != 1) begin
      errors++; $display("FAIL reset_first_fire: got %0d pending required 1", sbq.size());
    end
    tick();
    reset_n = 1'b0;
    #1;
    sbq.delete();
    lc_model = 0;
    checks++;
    if ({qcount, late_cnt, cmdstb, envstart, envlength, ampx, freqaddr, pini} !== '0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_hold: got q=%0d lc=%0d ready=%b required 0/0/1", qcount, late_cnt, cmd_ready);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (600) tick();
    checks++;
    if (qcount !== 3'd0) begin
      errors++; $display("FAIL reset_queue_dropped: got %0d required 0", qcount);
    end
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; cmd_valid = 1'b0; elem_busy = 1'b0; tcnt = '0;
    cmd_trigt = '0; cmd_envstart = '0; cmd_envlength = '0; cmd_ampx = '0;
    cmd_freqaddr = '0; cmd_pini = '0;
    test_reset();
    test_single();
    test_fill();
    test_late();
    test_busy();
    test_wrap();
    test_flush_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
